// File: rtl/seq_mul_unit.sv
// Iterative shift-add multiplier: one multiplier bit per clock, signed/unsigned per operation.
// Optional early termination when the remaining multiplier bits are zero: define EARLY_TERM_EN.
module seq_mul_unit #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StSign
    } state_e;

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] mag_a_q, mag_a_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH-1:0]   mag_b_shift;
    logic               run_last;

    // |-2^(W-1)| wraps to 2^(W-1), which is the correct unsigned magnitude.
    always_comb begin
        abs_a       = (signed_mode && a[WIDTH-1]) ? -a : a;
        abs_b       = (signed_mode && b[WIDTH-1]) ? -b : b;
        mag_b_shift = mag_b_q >> 1;
`ifdef EARLY_TERM_EN
        run_last    = (mag_b_shift == '0) || (cnt_q == CNT_W'(1));
`else
        run_last    = (cnt_q == CNT_W'(1));
`endif
    end

    always_comb begin
        state_d   = state_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mag_a_d = {{WIDTH{1'b0}}, abs_a};
                    mag_b_d = abs_b;
                    neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = StRun;
                end
            end
            StRun: begin
                if (mag_b_q[0]) begin
                    acc_d = acc_q + mag_a_q;
                end
                mag_a_d = mag_a_q << 1;
                mag_b_d = mag_b_shift;
                cnt_d   = cnt_q - CNT_W'(1);
                if (run_last) begin
                    state_d = StSign;
                end
            end
            StSign: begin
                product_d = neg_q ? -acc_q : acc_q;
                done_d    = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign product = product_q;

endmodule
